// File: rtl/scomp_arb_pkg.sv
// Shared types for the scomp_arb compare arbiter.
// FSM state encoding and statistics counter width.
package scomp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/scomp_arb_cmp.sv
// Combinational two's-complement magnitude comparator (module scomp_cmp).
// Exactly one of gt/lt/eq is asserted for any input pair.
module scomp_cmp #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    output logic                 gt_o,
    output logic                 lt_o,
    output logic                 eq_o
);

    logic sa;
    logic sb;

    assign sa = a_i[DATAWIDTH-1];
    assign sb = b_i[DATAWIDTH-1];

    // Opposite signs: the negative operand is the smaller one.
    always_comb begin
        gt_o = 1'b0;
        lt_o = 1'b0;
        eq_o = 1'b0;
        if (sa != sb) begin
            gt_o = sb;
            lt_o = sa;
        end else begin
            gt_o = (a_i > b_i);
            lt_o = (a_i < b_i);
            eq_o = (a_i == b_i);
        end
    end

endmodule

// File: rtl/scomp_arb.sv
// Round-robin arbiter sharing one signed comparator among NREQ requesters.
// Define SCOMP_ARB_STATS_EN to add the saturating stat_cnt output.
module scomp_arb
    import scomp_arb_pkg::*;
#(
    parameter  int DATAWIDTH = 8,
    parameter  int NREQ      = 4,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATAWIDTH-1:0] req_a,
    input  logic [NREQ*DATAWIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_gt,
    output logic                      rsp_lt,
    output logic                      rsp_eq
`ifdef SCOMP_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]         stat_cnt
`endif
);

    state_e               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       id_q;
    logic [DATAWIDTH-1:0] a_q;
    logic [DATAWIDTH-1:0] b_q;
    logic                 vld_q;
    logic                 gt_q;
    logic                 lt_q;
    logic                 eq_q;

    logic                 win_vld;
    logic [IDW-1:0]       win_id;
    logic [IDW-1:0]       cand;
    logic [DATAWIDTH-1:0] win_a;
    logic [DATAWIDTH-1:0] win_b;
    logic                 cmp_gt;
    logic                 cmp_lt;
    logic                 cmp_eq;
    logic                 take;

    // Scan farthest-first so the nearest valid slot after ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (req_valid[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        win_a = req_a[int'(win_id)*DATAWIDTH +: DATAWIDTH];
        win_b = req_b[int'(win_id)*DATAWIDTH +: DATAWIDTH];
    end

    assign take      = (state_q == ST_IDLE) && win_vld;
    assign req_ready = take ? (NREQ'(1) << win_id) : '0;

    scomp_cmp #(
        .DATAWIDTH(DATAWIDTH)
    ) u_cmp (
        .a_i (a_q),
        .b_i (b_q),
        .gt_o(cmp_gt),
        .lt_o(cmp_lt),
        .eq_o(cmp_eq)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vld_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        a_q     <= win_a;
                        b_q     <= win_b;
                        id_q    <= win_id;
                        ptr_q   <= win_id;
                        state_q <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    gt_q    <= cmp_gt;
                    lt_q    <= cmp_lt;
                    eq_q    <= cmp_eq;
                    vld_q   <= 1'b1;
                    state_q <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_gt    = gt_q;
    assign rsp_lt    = lt_q;
    assign rsp_eq    = eq_q;

`ifdef SCOMP_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stat_q <= '0;
        end else if ((state_q == ST_RSP) && vld_q && rsp_ready
                     && (stat_q != {STAT_W{1'b1}})) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_scomp_arb.sv
// Directed scoreboard bench for scomp_arb (DATAWIDTH=8, NREQ=4).
// Stats checks compile only with SCOMP_ARB_STATS_EN.
module tb_scomp_arb;

    localparam int DW = 8;
    localparam int NR = 4;

    typedef struct packed {
        logic [1:0] id;
        logic       gt;
        logic       lt;
        logic       eq;
    } exp_t;

    logic            Clk = 1'b0;
    logic            Rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic            rsp_gt;
    logic            rsp_lt;
    logic            rsp_eq;
`ifdef SCOMP_ARB_STATS_EN
    logic [15:0]     stat_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    scomp_arb #(.DATAWIDTH(DW), .NREQ(NR)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_gt   (rsp_gt),
        .rsp_lt   (rsp_lt),
        .rsp_eq   (rsp_eq)
`ifdef SCOMP_ARB_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [7:0] a,
                                   input logic [7:0] b);
        exp_t e;
        e.id = 2'(id);
        e.gt = ($signed(a) > $signed(b));
        e.lt = ($signed(a) < $signed(b));
        e.eq = (a == b);
        return e;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Record transfers before the edge, then advance to 1 time unit past it.
    task automatic step();
        exp_t e;
        if (!Rst) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i])
                    sb.push_back(model(i, req_a[i*DW +: DW], req_b[i*DW +: DW]));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_flags", {29'd0, rsp_gt, rsp_lt, rsp_eq},
                        {29'd0, e.gt, e.lt, e.eq});
                    chk("rsp_onehot", 32'(rsp_gt) + 32'(rsp_lt) + 32'(rsp_eq), 1);
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() > 0; i++) step();
        chk("drain_left", 32'(sb.size()), 0);
    endtask

    task automatic run_one(input int id, input logic [7:0] a,
                           input logic [7:0] b);
        int n = 0;
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_valid = NR'(1) << id;
        #1;
        while (!req_ready[id] && n < 10) begin
            step();
            n++;
        end
        chk("grant_wait", 32'(req_ready[id]), 1);
        step();
        req_valid = '0;
        drain();
    endtask

    task automatic pulse_rst();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   g;
        Rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_flags", {29'd0, rsp_gt, rsp_lt, rsp_eq}, 0);
        Rst = 1'b0;

        // Single request from requester 2: -128 vs 127.
        req_a[2*DW +: DW] = 8'h80;
        req_b[2*DW +: DW] = 8'h7F;
        req_valid = 4'b0100;
        #1;
        chk("t1_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        #1;
        chk("t1_cmp_ready", 32'(req_ready), 0);
        chk("t1_cmp_valid", 32'(rsp_valid), 0);
        step();
        chk("t1_valid", 32'(rsp_valid), 1);
        chk("t1_id", 32'(rsp_id), 2);
        chk("t1_lt", 32'(rsp_lt), 1);
        drain();

        run_one(0, 8'hFE, 8'hFF);
        run_one(1, 8'h05, 8'h03);
        run_one(3, 8'h80, 8'h80);
        run_one(2, 8'h7F, 8'h80);
        run_one(0, 8'h00, 8'hFF);

        // Fairness with all requesters held valid from reset.
        pulse_rst();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = 8'(i * 37 - 50);
            req_b[i*DW +: DW] = 8'h10;
        end
        req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = 0;
            while (req_ready == '0 && g < 10) begin
                step();
                g++;
            end
            chk("fair_grant", 32'(oh2idx(req_ready)), 32'(k % NR));
            step();
        end
        req_valid = '0;
        drain();

        // Backpressure on the response channel.
        rsp_ready = 1'b0;
        req_a[1*DW +: DW] = 8'h05;
        req_b[1*DW +: DW] = 8'h03;
        req_a[3*DW +: DW] = 8'h81;
        req_b[3*DW +: DW] = 8'h82;
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1000;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_hold", {27'd0, rsp_id, rsp_gt, rsp_lt, rsp_eq},
                {27'd0, 2'd1, 3'b100});
            chk("bp_noready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_regrant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        drain();

        // Reset while in CMP discards the transaction.
        req_a[2*DW +: DW] = 8'h11;
        req_b[2*DW +: DW] = 8'h22;
        req_valid = 4'b0100;
        #1;
        step();
        req_valid = '0;
        Rst = 1'b1;
        step();
        sb.delete();
        chk("rm_valid", 32'(rsp_valid), 0);
        Rst = 1'b0;
        step();
        chk("rm_noresp", 32'(rsp_valid), 0);
        req_a[0] = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("rm_first", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        drain();

`ifdef SCOMP_ARB_STATS_EN
        pulse_rst();
        chk("st_clear", 32'(stat_cnt), 0);
        run_one(0, 8'h01, 8'h02);
        run_one(1, 8'h03, 8'h02);
        run_one(2, 8'h04, 8'h04);
        chk("st_three", 32'(stat_cnt), 3);
        force dut.stat_q = 16'hFFFF;
        step();
        release dut.stat_q;
        run_one(3, 8'h09, 8'h08);
        chk("st_sat", 32'(stat_cnt), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
